fm_param_fetch: RTL

Avalon-MM master that periodically snapshots the 4-word x 32-bit patch-parameter on-chip RAM into a registered parameter bus for the FM operator datapath. On each sample_tick it burst-reads words 0..3 over a single-port RAM interface with synchronous read. It then commits all four words atomically. Host parameter writes share the same RAM port through this block, and the block stalls them with waitrequest while a fetch is in flight.

---
 rtl/fm_synth_pkg.sv | 24 ++
 rtl/fm_param_port_mux.sv | 41 ++++
 rtl/fm_param_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fm_synth_pkg.sv
// rtl/fm_synth_pkg.sv - shared constants, state enum and parameter-word names for the FM parameter fetcher
package fm_synth_pkg;

    localparam int FM_NUM_WORDS = 4;
    localparam int FM_ADDR_W    = 2;
    localparam int FM_DATA_W    = 32;

    // Word slots of the patch-parameter RAM as seen by the operator datapath
    localparam int PW_RATIO = 0;
    localparam int PW_LEVEL = 1;
    localparam int PW_ENV   = 2;
    localparam int PW_FB    = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic int pw_lsb(input int k);
        return k * FM_DATA_W;
    endfunction

endpackage

// File: rtl/fm_param_port_mux.sv
// rtl/fm_param_port_mux.sv - steers host writes or fetch reads onto the single RAM port
module fm_param_port_mux #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                  idle_free_i,
    input  logic                  fetch_rd_i,
    input  logic [ADDR_W-1:0]     fetch_addr_i,
    input  logic [ADDR_W-1:0]     host_address_i,
    input  logic                  host_write_i,
    input  logic [DATA_W-1:0]     host_writedata_i,
    input  logic [DATA_W/8-1:0]   host_byteenable_i,
    output logic                  host_waitrequest_o,
    output logic [ADDR_W-1:0]     mem_address_o,
    output logic                  mem_chipselect_o,
    output logic                  mem_write_o,
    output logic [DATA_W-1:0]     mem_writedata_o,
    output logic [DATA_W/8-1:0]   mem_byteenable_o
);

    logic host_grant;

    // The port only belongs to the host in an IDLE cycle with no refresh queued
    assign host_grant         = idle_free_i & host_write_i;
    assign host_waitrequest_o = ~idle_free_i;

    always_comb begin
        mem_address_o    = fetch_addr_i;
        mem_chipselect_o = fetch_rd_i;
        mem_write_o      = 1'b0;
        mem_writedata_o  = host_writedata_i;
        mem_byteenable_o = '1;
        if (host_grant) begin
            mem_address_o    = host_address_i;
            mem_chipselect_o = 1'b1;
            mem_write_o      = 1'b1;
            mem_byteenable_o = host_byteenable_i;
        end
    end

endmodule

// File: rtl/fm_param_fetch.sv
// rtl/fm_param_fetch.sv - periodic burst snapshot of the patch-parameter RAM into a registered parameter bus
module fm_param_fetch
    import fm_synth_pkg::*;
#(
    parameter int NUM_WORDS = FM_NUM_WORDS,
    parameter int ADDR_W    = FM_ADDR_W,
    parameter int DATA_W    = FM_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sample_tick,
    input  logic [ADDR_W-1:0]             host_address,
    input  logic                          host_write,
    input  logic [DATA_W-1:0]             host_writedata,
    input  logic [DATA_W/8-1:0]           host_byteenable,
    output logic                          host_waitrequest,
    output logic [ADDR_W-1:0]             mem_address,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic [DATA_W/8-1:0]           mem_byteenable,
    input  logic [DATA_W-1:0]             mem_readdata,
    output logic [NUM_WORDS*DATA_W-1:0]   param_out,
    output logic                          param_valid,
    output logic                          busy,
    output logic                          overrun,
    input  logic                          clr_overrun
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    fetch_state_e                  state_q;
    logic [ADDR_W-1:0]             rd_idx_q;
    logic                          pending_q;
    logic                          overrun_q;
    logic                          param_valid_q;
    logic [DATA_W-1:0]             shadow_q [NUM_WORDS-1];
    logic [NUM_WORDS*DATA_W-1:0]   param_q;

    logic idle_free;
    logic fetch_rd;
    logic overrun_set;

    assign idle_free   = (state_q == ST_IDLE) && !pending_q;
    assign fetch_rd    = (state_q == ST_FETCH);
    // Only one refresh can be queued; a tick arriving with one already queued is lost
    assign overrun_set = sample_tick & pending_q;

    fm_param_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .idle_free_i        (idle_free),
        .fetch_rd_i         (fetch_rd),
        .fetch_addr_i       (rd_idx_q),
        .host_address_i     (host_address),
        .host_write_i       (host_write),
        .host_writedata_i   (host_writedata),
        .host_byteenable_i  (host_byteenable),
        .host_waitrequest_o (host_waitrequest),
        .mem_address_o      (mem_address),
        .mem_chipselect_o   (mem_chipselect),
        .mem_write_o        (mem_write),
        .mem_writedata_o    (mem_writedata),
        .mem_byteenable_o   (mem_byteenable)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rd_idx_q      <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            param_valid_q <= 1'b0;
            param_q       <= '0;
            for (int k = 0; k < NUM_WORDS - 1; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            param_valid_q <= 1'b0;
            overrun_q     <= overrun_set | (overrun_q & ~clr_overrun);

            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        state_q   <= ST_FETCH;
                        pending_q <= 1'b0;
                    end else if (host_write) begin
                        if (sample_tick) begin
                            pending_q <= 1'b1;
                        end
                    end else if (sample_tick) begin
                        state_q <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // Read data lags the address by one cycle, so it lands one slot behind rd_idx
                    for (int k = 0; k < NUM_WORDS - 1; k++) begin
                        if (rd_idx_q == ADDR_W'(k + 1)) begin
                            shadow_q[k] <= mem_readdata;
                        end
                    end
                    if (sample_tick) begin
                        pending_q <= 1'b1;
                    end
                    if (rd_idx_q == LAST_IDX) begin
                        state_q  <= ST_DRAIN;
                        rd_idx_q <= '0;
                    end else begin
                        rd_idx_q <= rd_idx_q + ADDR_W'(1);
                    end
                end

                ST_DRAIN: begin
                    for (int k = 0; k < NUM_WORDS - 1; k++) begin
                        param_q[k*DATA_W +: DATA_W] <= shadow_q[k];
                    end
                    param_q[(NUM_WORDS-1)*DATA_W +: DATA_W] <= mem_readdata;
                    param_valid_q <= 1'b1;
                    if (pending_q) begin
                        state_q   <= ST_FETCH;
                        pending_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        if (sample_tick) begin
                            pending_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign param_out   = param_q;
    assign param_valid = param_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = overrun_q;

endmodule
